// File: rtl/timer_pkg.sv
// Shared constants and types for the FF05..FF07 timer block.
package timer_pkg;

    localparam logic [1:0] TIMA_A  = 2'b01;
    localparam logic [1:0] TMA_A   = 2'b10;
    localparam logic [1:0] TAC_A   = 2'b11;
    localparam logic [7:0] TAC_PAD = 8'hF8;

    typedef enum logic [1:0] {
        SEL_4096   = 2'b00,
        SEL_262144 = 2'b01,
        SEL_65536  = 2'b10,
        SEL_16384  = 2'b11
    } tac_sel_t;

endpackage

// File: rtl/timer_tick_det.sv
// Selects the divider tap named by TAC, gates it with the enable bit and
// emits a one-clk inc on every falling edge of the gated source.
module timer_tick_det
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] tac_eff,
    input  logic       div_4096hz,
    input  logic       div_16384hz,
    input  logic       div_65536hz,
    input  logic       div_262144hz,
    output logic       inc
);

    logic tap_sel;
    logic tick_src;
    logic tap_q;

    always_comb begin
        tap_sel = 1'b0;
        case (tac_sel_t'(tac_eff[1:0]))
            SEL_4096:   tap_sel = div_4096hz;
            SEL_262144: tap_sel = div_262144hz;
            SEL_65536:  tap_sel = div_65536hz;
            SEL_16384:  tap_sel = div_16384hz;
        endcase
    end

    // Disabling or reselecting while the old source is high is seen as a
    // falling edge; that extra tick is deliberate.
    assign tick_src = tap_sel & tac_eff[2];
    assign inc      = tap_q & ~tick_src;

    always_ff @(posedge clk) begin
        if (reset) tap_q <= 1'b0;
        else       tap_q <= tick_src;
    end

endmodule

// File: rtl/timer_tima.sv
// TIMA/TMA/TAC timer: counts selected divider edges, reloads from TMA one
// M-cycle after overflow and pulses int_timer on the reload clk.
module timer_tima
    import timer_pkg::*;
#(
    parameter int OVF_DELAY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ff04_ff07,
    input  logic [1:0] a,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic       div_4096hz,
    input  logic       div_16384hz,
    input  logic       div_65536hz,
    input  logic       div_262144hz,
    output logic       int_timer
);

    localparam int CNT_W = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;

    // Bus: cpu_wr/cpu_rd are single-clk strobes qualified by ff04_ff07; a read
    // answers the next clk with d_oe high for exactly one clk, no back-pressure.
    logic [7:0]       tima;
    logic [7:0]       tma;
    logic [2:0]       tac;
    logic [CNT_W-1:0] ovf_cnt;
    logic             ovf_pend;
    logic             wr_tima, wr_tma, wr_tac, rd_hit;
    logic             reload;
    logic             inc;
    logic [2:0]       tac_eff;

    assign wr_tima = cpu_wr & ff04_ff07 & (a == TIMA_A);
    assign wr_tma  = cpu_wr & ff04_ff07 & (a == TMA_A);
    assign wr_tac  = cpu_wr & ff04_ff07 & (a == TAC_A);
    assign rd_hit  = cpu_rd & ff04_ff07 & (a != 2'b00);
    assign reload  = ovf_pend & (ovf_cnt == '0);
    assign tac_eff = wr_tac ? d_in[2:0] : tac;

    timer_tick_det u_tick_det (
        .clk          (clk),
        .reset        (reset),
        .tac_eff      (tac_eff),
        .div_4096hz   (div_4096hz),
        .div_16384hz  (div_16384hz),
        .div_65536hz  (div_65536hz),
        .div_262144hz (div_262144hz),
        .inc          (inc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            ovf_cnt   <= '0;
            ovf_pend  <= 1'b0;
            int_timer <= 1'b0;
        end else begin
            int_timer <= 1'b0;
            if (wr_tac) tac <= d_in[2:0];
            if (wr_tma) tma <= d_in;
            if (ovf_pend && !reload) ovf_cnt <= ovf_cnt - 1'b1;

            // Reload beats a TIMA write; a same-clk TMA write feeds the reload.
            if (reload) begin
                tima      <= wr_tma ? d_in : tma;
                int_timer <= 1'b1;
                ovf_pend  <= 1'b0;
            end else if (wr_tima) begin
                tima     <= d_in;
                ovf_pend <= 1'b0;
            end else if (inc) begin
                if (tima == 8'hFF) begin
                    tima     <= 8'h00;
                    ovf_pend <= 1'b1;
                    ovf_cnt  <= CNT_W'(OVF_DELAY - 1);
                end else begin
                    tima <= tima + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_oe  <= 1'b0;
            d_out <= 8'h00;
        end else begin
            d_oe  <= rd_hit;
            d_out <= 8'h00;
            if (rd_hit) begin
                case (a)
                    TIMA_A:  d_out <= tima;
                    TMA_A:   d_out <= tma;
                    TAC_A:   d_out <= TAC_PAD | {5'b00000, tac};
                    default: d_out <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_tima.sv
// Directed bench for timer_tima: a cycle-level reference model checked every
// clk, plus literal register/irq expectations at key points.
module tb_timer_tima;

    localparam int OVF_DELAY = 4;

    logic       clk;
    logic       reset;
    logic       ff04_ff07;
    logic [1:0] a;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       div_4096hz, div_16384hz, div_65536hz, div_262144hz;
    logic       int_timer;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    timer_tima #(.OVF_DELAY(OVF_DELAY)) dut (
        .clk          (clk),
        .reset        (reset),
        .ff04_ff07    (ff04_ff07),
        .a            (a),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .d_in         (d_in),
        .d_out        (d_out),
        .d_oe         (d_oe),
        .div_4096hz   (div_4096hz),
        .div_16384hz  (div_16384hz),
        .div_65536hz  (div_65536hz),
        .div_262144hz (div_262144hz),
        .int_timer    (int_timer)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int         cyc = 0;
    int         reload_at = -1;
    logic [7:0] m_tima, m_tma;
    logic [2:0] m_tac;
    logic       m_prev, m_irq, m_oe;
    logic [7:0] m_dout;

    function automatic logic tap_of(input logic [1:0] s);
        case (s)
            2'd0:    return div_4096hz;
            2'd1:    return div_262144hz;
            2'd2:    return div_65536hz;
            default: return div_16384hz;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [2:0] tac_now;
        logic       src, fall, hit;
        cyc = cyc + 1;
        if (reset) begin
            m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
            m_prev = 1'b0; m_irq = 1'b0; m_oe = 1'b0; m_dout = 8'h00;
            reload_at = -1;
        end else begin
            hit     = ff04_ff07 & cpu_wr;
            tac_now = (hit && a == 2'd3) ? d_in[2:0] : m_tac;
            src     = tac_now[2] & tap_of(tac_now[1:0]);
            fall    = m_prev & !src;
            m_prev  = src;
            m_irq   = 1'b0;
            m_oe    = cpu_rd & ff04_ff07 & (a != 2'd0);
            m_dout  = !m_oe ? 8'h00 : (a == 2'd1) ? m_tima :
                      (a == 2'd2) ? m_tma : (8'hF8 | {5'd0, m_tac});
            if (hit && a == 2'd3) m_tac = d_in[2:0];
            if (hit && a == 2'd2) m_tma = d_in;
            if (reload_at == cyc) begin
                m_tima = m_tma;
                m_irq = 1'b1;
                reload_at = -1;
            end else if (hit && a == 2'd1) begin
                m_tima = d_in;
                reload_at = -1;
            end else if (fall) begin
                if (m_tima == 8'hFF) reload_at = cyc + OVF_DELAY;
                m_tima = m_tima + 8'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%02h expected=%02h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("irq_model", {7'd0, int_timer}, {7'd0, m_irq});
            chk("doe_model", {7'd0, d_oe}, {7'd0, m_oe});
            if (m_oe) chk("dout_model", d_out, m_dout);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        ff04_ff07 = 1'b1; cpu_wr = 1'b1; a = addr; d_in = data;
        @(negedge clk);
        ff04_ff07 = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] addr, input logic [7:0] exp);
        ff04_ff07 = 1'b1; cpu_rd = 1'b1; a = addr;
        @(negedge clk);
        ff04_ff07 = 1'b0; cpu_rd = 1'b0;
        chk({name, "_oe"}, {7'd0, d_oe}, 8'd1);
        chk(name, d_out, exp);
    endtask

    task automatic tap(input logic v);
        div_262144hz = v;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; ff04_ff07 = 1'b0; a = 2'd0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        d_in = 8'h00; div_4096hz = 1'b0; div_16384hz = 1'b0;
        div_65536hz = 1'b0; div_262144hz = 1'b0;
        idle(3);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset values
        rd_chk("rst_tima", 2'd1, 8'h00);
        rd_chk("rst_tma",  2'd2, 8'h00);
        rd_chk("rst_tac",  2'd3, 8'hF8);
        ff04_ff07 = 1'b1; cpu_rd = 1'b1; a = 2'd0;
        @(negedge clk);
        ff04_ff07 = 1'b0; cpu_rd = 1'b0;
        chk("div_addr_no_oe", {7'd0, d_oe}, 8'd0);

        // Count FE -> FF -> overflow -> reload from TMA
        wr(2'd2, 8'h42);
        wr(2'd3, 8'h05);
        wr(2'd1, 8'hFE);
        tap(1); tap(0);
        rd_chk("inc_ff", 2'd1, 8'hFF);
        tap(1); tap(0);
        rd_chk("win_zero", 2'd1, 8'h00);
        idle(2);
        chk("irq_before", {7'd0, int_timer}, 8'd0);
        idle(1);
        chk("irq_reload", {7'd0, int_timer}, 8'd1);
        rd_chk("reload_tima", 2'd1, 8'h42);
        chk("irq_one_clk", {7'd0, int_timer}, 8'd0);

        // TIMA write inside the window cancels reload
        wr(2'd1, 8'hFF);
        tap(1); tap(0);
        idle(1);
        wr(2'd1, 8'h10);
        idle(5);
        rd_chk("cancel_tima", 2'd1, 8'h10);

        // TMA write on the reload clk
        wr(2'd1, 8'hFF);
        tap(1); tap(0);
        idle(3);
        wr(2'd2, 8'h77);
        chk("irq_tma_wr", {7'd0, int_timer}, 8'd1);
        rd_chk("tma_wr_tima", 2'd1, 8'h77);
        rd_chk("tma_wr_tma",  2'd2, 8'h77);

        // TIMA write in the same clk as an inc: write wins
        tap(1);
        div_262144hz = 1'b0;
        wr(2'd1, 8'h30);
        rd_chk("wr_beats_inc", 2'd1, 8'h30);

        // Disabling TAC while the 4096 tap is high gives one inc
        div_4096hz = 1'b1;
        wr(2'd3, 8'h04);
        idle(2);
        rd_chk("tac4_no_inc", 2'd1, 8'h30);
        wr(2'd3, 8'h00);
        rd_chk("tac_off_inc", 2'd1, 8'h31);
        div_4096hz = 1'b0;
        idle(2);
        rd_chk("tac_off_once", 2'd1, 8'h31);
        rd_chk("tac_zero", 2'd3, 8'hF8);

        // Reset two clk into the window aborts the reload
        wr(2'd3, 8'h05);
        wr(2'd2, 8'h55);
        wr(2'd1, 8'hFF);
        tap(1); tap(0);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(6);
        rd_chk("rstwin_tima", 2'd1, 8'h00);
        rd_chk("rstwin_tma",  2'd2, 8'h00);
        rd_chk("rstwin_tac",  2'd3, 8'hF8);
        chk("rstwin_irq", {7'd0, int_timer}, 8'd0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
